wb_host_bridge: RTL and testbench
=================================

# wb_host_bridge

Wishbone classic single-transfer initiator that drives the user project's Wishbone slave port from a valid/ready command interface. Each accepted command becomes exactly one Wishbone read or write cycle, and its result returns on a valid/ready response channel. A cycle counter aborts hung transfers. The bridge lets on-chip logic and the verification bench exercise the RNG project's register map without the management SoC.

## Interface
Parameters:
- TIMEOUT, default 255: maximum cycles in BUS without ack before abort; legal range 1..65535.
- ERR_DATA, default 32'hDEAD_BEEF: value returned on rsp_dat_o for a timed-out transfer.

Ports:
- wb_clk_i, input, 1: the single clock; all logic is on its rising edge.
- wb_rst_i, input, 1: reset, asynchronous assert, active-high.
- cmd_valid_i, input, 1: a command is presented.
- cmd_ready_o, output, 1: the bridge can accept a command (IDLE only).
- cmd_we_i, input, 1: 1 = write, 0 = read.
- cmd_adr_i, input, 32: byte address.
- cmd_dat_i, input, 32: write data.
- cmd_sel_i, input, 4: byte lane selects.
- rsp_valid_o, output, 1: a response is held.
- rsp_ready_i, input, 1: the consumer accepts the response.
- rsp_dat_o, output, 32: read data; 0 for writes; ERR_DATA on timeout.
- rsp_err_o, output, 1: 1 = the transfer timed out.
- wbm_cyc_o, output, 1: Wishbone CYC.
- wbm_stb_o, output, 1: Wishbone STB.
- wbm_we_o, output, 1: Wishbone WE.
- wbm_sel_o, output, 4: Wishbone SEL.
- wbm_adr_o, output, 32: Wishbone ADR.
- wbm_dat_o, output, 32: Wishbone write data.
- wbm_ack_i, input, 1: Wishbone ACK.
- wbm_dat_i, input, 32: Wishbone read data.

## Operation
- FSM states: IDLE, BUS, RESP. Reset state is IDLE.
- IDLE:
  - cmd_ready_o = 1.
  - On cmd_valid_i & cmd_ready_o at an edge: register we/adr/dat/sel onto the wbm_* outputs, assert cyc and stb, clear the timeout counter, go to BUS.
- BUS:
  - wbm_cyc_o = wbm_stb_o = 1.
  - All wbm_* outputs stay stable until the cycle ends.
  - Counter increments every cycle.
  - If wbm_ack_i = 1 at an edge: deassert cyc/stb on that edge, latch rsp_dat_o (wbm_dat_i for reads, 0 for writes), set rsp_err_o = 0, go to RESP.
  - Otherwise, if the counter equals TIMEOUT-1 at an edge: deassert cyc/stb, set rsp_dat_o = ERR_DATA and rsp_err_o = 1, go to RESP.
  - Ack wins over timeout when both occur on the same edge.
- RESP:
  - rsp_valid_o = 1; rsp_dat_o and rsp_err_o are held stable.
  - On rsp_ready_i = 1 at an edge: go to IDLE.
  - No new command is accepted in the same edge.
- wbm_ack_i outside BUS is ignored: no state change and no response.
- Counter width is clog2(TIMEOUT+1). The counter saturates and never wraps.
- Reset values:
  - cmd_ready_o = 1.
  - rsp_valid_o, rsp_err_o, wbm_cyc_o, wbm_stb_o, wbm_we_o = 0.
  - wbm_sel_o, wbm_adr_o, wbm_dat_o, rsp_dat_o = 0.
- Reset during BUS drops cyc/stb immediately (asynchronously). The in-flight command produces no response.
- Reset during RESP discards the pending response.

## Timing
- Command accepted at edge N: wbm_cyc_o/wbm_stb_o are high from N until the ack edge.
- Slave acks at edge N+k (k ≥ 1): rsp_valid_o is high from edge N+k. Minimum command-to-response latency is 1 cycle (combinational slave ack).
- Response consumed at edge M: cmd_ready_o is high from M, so the next command can be accepted at M+1.
- Back-to-back throughput: one transfer per 3 cycles minimum, with a zero-wait slave and rsp_ready_i held high.
- Timeout: with no ack, cyc drops and rsp_err_o rises exactly TIMEOUT cycles after the accept edge.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Package wb_host_pkg holds:
  - state typedef {IDLE, BUS, RESP}
  - WB_DW = 32, WB_AW = 32, WB_SELW = 4
  - default ERR_DATA constant
- One natural sub-module: wb_timeout_ctr, a clear/enable saturating counter with a terminal-count output.
- The top-level FSM and output registers live in wb_host_bridge.

## Test plan
- Write then read: write 0x3000_0004 ← 0xA5A5_1234 with sel = 0xF, then read the same address.
  - Slave ack delays of 0, 1 and 3 cycles.
  - Required: rsp_dat_o = 0xA5A5_1234, rsp_err_o = 0; a read with ack at edge N+1 gives rsp_valid_o at N+1.
- Timeout with TIMEOUT = 8, slave never acks.
  - Required: cyc drops and rsp_valid_o/rsp_err_o rise 8 cycles after accept; rsp_dat_o = 0xDEAD_BEEF.
- Ack on the timeout edge: slave acks exactly at cycle 8.
  - Required: rsp_err_o = 0 and the read data is returned.
- Response backpressure and command hold-off: hold rsp_ready_i = 0 for 5 cycles while cmd_valid_i stays high.
  - Required: cmd_ready_o = 0 and rsp_* stable throughout; the next accept occurs one edge after the response handshake.
- Spurious ack and reset:
  - wbm_ack_i pulsed while IDLE → no response.
  - wb_rst_i asserted mid-BUS → cyc/stb low in the same cycle, no response after release, cmd_ready_o = 1.

Source files
------------

// File: rtl/wb_host_pkg.sv
// wb_host_pkg: shared types and bus widths for the Wishbone host bridge.
`default_nettype none

package wb_host_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WB_DW   = 32;
    localparam int WB_AW   = 32;
    localparam int WB_SELW = 4;

    localparam logic [WB_DW-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

`default_nettype wire

// File: rtl/wb_timeout_ctr.sv
// wb_timeout_ctr: clear/enable saturating cycle counter with a terminal-count flag.
`default_nettype none

module wb_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int             CW     = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  SAT    = CW'(TIMEOUT);
    localparam logic [CW-1:0]  TC_VAL = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // Saturates at TIMEOUT so a stalled enable can never wrap back to terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != SAT)) begin
            count <= count + CW'(1);
        end
    end

    assign tc = (count == TC_VAL);

endmodule

`default_nettype wire

// File: rtl/wb_host_bridge.sv
// wb_host_bridge: valid/ready command to Wishbone classic single-transfer initiator
// with a timeout abort and a registered valid/ready response channel.
`default_nettype none

module wb_host_bridge
    import wb_host_pkg::*;
#(
    parameter int                TIMEOUT  = 255,
    parameter logic [WB_DW-1:0]  ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_we_i,
    input  logic [WB_AW-1:0]    cmd_adr_i,
    input  logic [WB_DW-1:0]    cmd_dat_i,
    input  logic [WB_SELW-1:0]  cmd_sel_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [WB_DW-1:0]    rsp_dat_o,
    output logic                rsp_err_o,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [WB_SELW-1:0]  wbm_sel_o,
    output logic [WB_AW-1:0]    wbm_adr_o,
    output logic [WB_DW-1:0]    wbm_dat_o,
    input  logic                wbm_ack_i,
    input  logic [WB_DW-1:0]    wbm_dat_i
);

    state_t state, state_next;
    logic   accept, ack_hit, to_hit, tc;

    wb_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .clr (accept),
        .en  (state == BUS),
        .tc  (tc)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Ack is tested before terminal count so a same-edge ack wins.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        ack_hit    = 1'b0;
        to_hit     = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid_i) begin
                    accept     = 1'b1;
                    state_next = BUS;
                end
            end
            BUS: begin
                if (wbm_ack_i) begin
                    ack_hit    = 1'b1;
                    state_next = RESP;
                end else if (tc) begin
                    to_hit     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake and strobe outputs are flops loaded from the next state,
    // keeping every port free of combinational paths from inputs.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cmd_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
        end else begin
            cmd_ready_o <= (state_next == IDLE);
            rsp_valid_o <= (state_next == RESP);
            wbm_cyc_o   <= (state_next == BUS);
            wbm_stb_o   <= (state_next == BUS);
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            rsp_dat_o <= '0;
            rsp_err_o <= 1'b0;
        end else begin
            if (accept) begin
                wbm_we_o  <= cmd_we_i;
                wbm_sel_o <= cmd_sel_i;
                wbm_adr_o <= cmd_adr_i;
                wbm_dat_o <= cmd_dat_i;
            end
            if (ack_hit) begin
                rsp_dat_o <= wbm_we_o ? '0 : wbm_dat_i;
                rsp_err_o <= 1'b0;
            end else if (to_hit) begin
                rsp_dat_o <= ERR_DATA;
                rsp_err_o <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wb_host_bridge.sv
// tb_wb_host_bridge: randomized self-checking bench with a behavioural slave and
// a transaction-level reference model of the bridge.
`default_nettype none

module tb_wb_host_bridge;

    localparam int          TO      = 8;
    localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0, cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [31:0] rsp_dat;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat, rdat;
    logic        ack;

    int          tests = 0;
    int          fails = 0;

    // Behavioural slave: acks ack_delay cycles after the strobe is first seen.
    int          ack_delay = 0;
    int          wait_cnt  = 0;
    logic        force_ack = 1'b0;
    logic [31:0] slave_mem [4];
    logic [31:0] ref_mem   [4];

    always #5 clk = ~clk;

    assign ack  = (cyc && stb && (wait_cnt >= ack_delay)) || force_ack;
    assign rdat = slave_mem[adr[3:2]];

    always @(posedge clk) begin
        if (!(cyc && stb)) wait_cnt <= 0;
        else               wait_cnt <= wait_cnt + 1;
        if (cyc && stb && ack && we) begin
            for (int b = 0; b < 4; b++)
                if (sel[b]) slave_mem[adr[3:2]][8*b +: 8] <= wdat[8*b +: 8];
        end
    end

    wb_host_bridge #(
        .TIMEOUT  (TO),
        .ERR_DATA (ERR_VAL)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_adr_i   (cmd_adr),
        .cmd_dat_i   (cmd_dat),
        .cmd_sel_i   (cmd_sel),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_dat_o   (rsp_dat),
        .rsp_err_o   (rsp_err),
        .wbm_cyc_o   (cyc),
        .wbm_stb_o   (stb),
        .wbm_we_o    (we),
        .wbm_sel_o   (sel),
        .wbm_adr_o   (adr),
        .wbm_dat_o   (wdat),
        .wbm_ack_i   (ack),
        .wbm_dat_i   (rdat)
    );

    // Full transfer against the reference: expected latency is the slave ack
    // time unless it exceeds TO, in which case the transfer times out at TO.
    task automatic do_xfer(input logic w, input int idx, input logic [31:0] d,
                           input logic [3:0] s, input int dly);
        logic        exp_err;
        int          exp_lat, lat;
        logic [31:0] exp_dat;
        exp_err = (dly + 1) > TO;
        exp_lat = exp_err ? TO : dly + 1;
        exp_dat = exp_err ? ERR_VAL : (w ? 32'h0 : ref_mem[idx]);
        if (!exp_err && w)
            for (int b = 0; b < 4; b++) if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];

        @(negedge clk);
        tests++;
        if (cmd_ready !== 1'b1) begin
            fails++; $display("FAIL xfer_ready_idle: cmd_ready=%b want 1", cmd_ready);
        end
        ack_delay = dly;
        cmd_valid = 1'b1; cmd_we = w; cmd_adr = 32'h3000_0000 | 32'(idx << 2);
        cmd_dat = d; cmd_sel = s;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        tests++;
        if ({cyc, stb, we, sel, adr, wdat} !== {1'b1, 1'b1, w, s, 32'h3000_0000 | 32'(idx << 2), d}) begin
            fails++;
            $display("FAIL xfer_bus_drive: cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h want we=%b sel=%h dat=%h",
                     cyc, stb, we, sel, adr, wdat, w, s, d);
        end
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        tests++;
        if (lat != exp_lat) begin
            fails++; $display("FAIL xfer_latency: got %0d cycles want %0d (delay %0d)", lat, exp_lat, dly);
        end
        tests++;
        if ({rsp_dat, rsp_err, cyc, stb} !== {exp_dat, exp_err, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL xfer_response: dat=%h err=%b cyc=%b stb=%b want dat=%h err=%b cyc=0 stb=0",
                     rsp_dat, rsp_err, cyc, stb, exp_dat, exp_err);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        tests++;
        if ({cmd_ready, rsp_valid} !== 2'b10) begin
            fails++; $display("FAIL xfer_consume: cmd_ready=%b rsp_valid=%b want 1 0", cmd_ready, rsp_valid);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({cmd_ready, rsp_valid, rsp_err, cyc, stb, we, sel, adr, wdat, rsp_dat} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0}) begin
            fails++;
            $display("FAIL reset_values: rdy=%b rv=%b err=%b cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h rdat=%h",
                     cmd_ready, rsp_valid, rsp_err, cyc, stb, we, sel, adr, wdat, rsp_dat);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write_read;
        int dl [3] = '{0, 1, 3};
        foreach (dl[i]) begin
            do_xfer(1'b1, 1, 32'hA5A5_1234, 4'hF, dl[i]);
            do_xfer(1'b0, 1, 32'h0, 4'hF, dl[i]);
        end
    endtask

    task automatic test_timeout;
        do_xfer(1'b0, 1, 32'h0, 4'hF, 50);
        do_xfer(1'b1, 2, 32'h1111_2222, 4'hF, TO);
        do_xfer(1'b0, 2, 32'h0, 4'hF, 0);
        do_xfer(1'b1, 3, 32'hCAFE_F00D, 4'hF, TO - 1);
        do_xfer(1'b0, 3, 32'h0, 4'hF, TO - 1);
    endtask

    task automatic test_random;
        for (int n = 0; n < 30; n++)
            do_xfer(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), $urandom,
                    4'($urandom_range(0, 15)), int'($urandom_range(0, 10)));
    endtask

    task automatic test_backpressure;
        logic [31:0] held;
        logic [31:0] nd;
        int          lat;
        nd = $urandom;
        @(negedge clk);
        ack_delay = 0;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0000; cmd_sel = 4'hF;
        @(posedge clk); #1;
        cmd_we = 1'b1; cmd_adr = 32'h3000_0008; cmd_dat = nd; cmd_sel = 4'hF;
        @(posedge clk); #1;
        held = ref_mem[0];
        for (int c = 0; c < 5; c++) begin
            tests++;
            if ({cmd_ready, rsp_valid, rsp_err, rsp_dat, cyc} !== {1'b0, 1'b1, 1'b0, held, 1'b0}) begin
                fails++;
                $display("FAIL bp_hold c%0d: rdy=%b rv=%b err=%b dat=%h cyc=%b want 0 1 0 %h 0",
                         c, cmd_ready, rsp_valid, rsp_err, rsp_dat, cyc, held);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        tests++;
        if ({cmd_ready, rsp_valid, cyc} !== 3'b100) begin
            fails++; $display("FAIL bp_release: rdy=%b rv=%b cyc=%b want 1 0 0", cmd_ready, rsp_valid, cyc);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        tests++;
        if ({cyc, we, adr, wdat} !== {1'b1, 1'b1, 32'h3000_0008, nd}) begin
            fails++; $display("FAIL bp_next_accept: cyc=%b we=%b adr=%h dat=%h want 1 1 30000008 %h",
                              cyc, we, adr, wdat, nd);
        end
        ref_mem[2] = nd;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        tests++;
        if ({lat == 1, rsp_dat, rsp_err} !== {1'b1, 32'h0, 1'b0}) begin
            fails++; $display("FAIL bp_write_rsp: lat=%0d dat=%h err=%b want 1 0 0", lat, rsp_dat, rsp_err);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        do_xfer(1'b0, 2, 32'h0, 4'hF, 2);
    endtask

    task automatic test_spurious_ack;
        @(negedge clk);
        force_ack = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            tests++;
            if ({rsp_valid, cmd_ready, cyc} !== 3'b010) begin
                fails++; $display("FAIL spurious_ack c%0d: rv=%b rdy=%b cyc=%b want 0 1 0",
                                  c, rsp_valid, cmd_ready, cyc);
            end
        end
        force_ack = 1'b0;
    endtask

    task automatic test_reset_mid_bus;
        @(negedge clk);
        ack_delay = 50;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0004; cmd_sel = 4'hF;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if ({cyc, stb} !== 2'b00) begin
            fails++; $display("FAIL reset_mid_bus_async: cyc=%b stb=%b want 0 0", cyc, stb);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            tests++;
            if ({rsp_valid, cmd_ready, cyc} !== 3'b010) begin
                fails++; $display("FAIL reset_mid_bus_after c%0d: rv=%b rdy=%b cyc=%b want 0 1 0",
                                  c, rsp_valid, cmd_ready, cyc);
            end
        end
        do_xfer(1'b0, 1, 32'h0, 4'hF, 1);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            slave_mem[i] = '0;
            ref_mem[i]   = '0;
        end
        test_reset;
        test_write_read;
        test_timeout;
        test_backpressure;
        test_spurious_ack;
        test_random;
        test_reset_mid_bus;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
